fft_reg_bank: RTL and testbench

Parametrised host-visible register bank that sits between the host bus and the FIR/FFT datapath; it replaces the fixed-size predecessor. It holds control/status, general-purpose, coefficient and FFT input/output regions sized by parameters. It adds a registered read with a valid/error handshake, read-only protection, a start/busy/done handshake to the FFT core, and an interrupt.

---
 rtl/fft_reg_bank_pkg.sv | 59 +++++
 rtl/fft_reg_decode.sv | 68 ++++++
 rtl/fft_reg_bank.sv | 214 +++++++++++++++++++++
 tb/tb_fft_reg_bank.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_reg_bank_pkg.sv
// fft_reg_bank_pkg
//   Shared definitions for the FFT/FIR host register bank: fixed addresses,
//   CTRL/STATUS bit positions, region base-address helpers and the region
//   enumeration produced by the address decoder.
package fft_reg_bank_pkg;

  localparam int CTRL_ADDR   = 0;
  localparam int STATUS_ADDR = 1;

  localparam int CTRL_START_BIT    = 0;
  localparam int CTRL_IRQ_EN_BIT   = 1;
  localparam int CTRL_DONE_CLR_BIT = 2;

  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_DONE_BIT = 1;

  typedef enum logic [3:0] {
    REG_CTRL,
    REG_STATUS,
    REG_GPR,
    REG_COEFF,
    REG_RIN,
    REG_IIN,
    REG_ROUT,
    REG_IOUT,
    REG_NONE
  } region_e;

  // Regions are laid out back to back in this order:
  // CTRL, STATUS, GPR, COEFF, REAL_IN, IMAG_IN, REAL_OUT, IMAG_OUT.
  function automatic int gpr_base();
    return 2;
  endfunction

  function automatic int coeff_base(input int n_gpr);
    return gpr_base() + n_gpr;
  endfunction

  function automatic int rin_base(input int n_gpr, input int n_coef);
    return coeff_base(n_gpr) + n_coef;
  endfunction

  function automatic int iin_base(input int n_gpr, input int n_coef, input int n_pts);
    return rin_base(n_gpr, n_coef) + n_pts;
  endfunction

  function automatic int rout_base(input int n_gpr, input int n_coef, input int n_pts);
    return iin_base(n_gpr, n_coef, n_pts) + n_pts;
  endfunction

  function automatic int iout_base(input int n_gpr, input int n_coef, input int n_pts);
    return rout_base(n_gpr, n_coef, n_pts) + n_pts;
  endfunction

  function automatic int total_regs(input int n_gpr, input int n_coef, input int n_pts);
    return iout_base(n_gpr, n_coef, n_pts) + n_pts;
  endfunction

endpackage

// File: rtl/fft_reg_decode.sv
// fft_reg_decode
//   Combinational address decoder shared by the read and write paths.
//   Ports:
//     addr     in   word address from the host bus
//     region   out  region the address falls in (REG_NONE when out of range)
//     offset   out  word offset inside that region
//     writable out  region is host-writable at all (busy gating is applied
//                   by the caller)
module fft_reg_decode
  import fft_reg_bank_pkg::*;
#(
  parameter int NUM_GPR_REGS    = 2,
  parameter int NUM_COEFFS_REGS = 30,
  parameter int FFT_POINTS      = 8,
  parameter int ADDR_W          = 7
) (
  input  logic [ADDR_W-1:0] addr,
  output region_e           region,
  output logic [ADDR_W-1:0] offset,
  output logic              writable
);

  localparam int GPR_B   = gpr_base();
  localparam int COEFF_B = coeff_base(NUM_GPR_REGS);
  localparam int RIN_B   = rin_base(NUM_GPR_REGS, NUM_COEFFS_REGS);
  localparam int IIN_B   = iin_base(NUM_GPR_REGS, NUM_COEFFS_REGS, FFT_POINTS);
  localparam int ROUT_B  = rout_base(NUM_GPR_REGS, NUM_COEFFS_REGS, FFT_POINTS);
  localparam int IOUT_B  = iout_base(NUM_GPR_REGS, NUM_COEFFS_REGS, FFT_POINTS);
  localparam int TOTAL   = total_regs(NUM_GPR_REGS, NUM_COEFFS_REGS, FFT_POINTS);

  logic [31:0] a;

  always_comb begin
    a        = 32'(addr);
    region   = REG_NONE;
    offset   = '0;
    writable = 1'b0;
    if (a == CTRL_ADDR) begin
      region   = REG_CTRL;
      writable = 1'b1;
    end else if (a == STATUS_ADDR) begin
      region = REG_STATUS;
    end else if (a < COEFF_B) begin
      region   = REG_GPR;
      offset   = ADDR_W'(a - GPR_B);
      writable = 1'b1;
    end else if (a < RIN_B) begin
      region   = REG_COEFF;
      offset   = ADDR_W'(a - COEFF_B);
      writable = 1'b1;
    end else if (a < IIN_B) begin
      region   = REG_RIN;
      offset   = ADDR_W'(a - RIN_B);
      writable = 1'b1;
    end else if (a < ROUT_B) begin
      region   = REG_IIN;
      offset   = ADDR_W'(a - IIN_B);
      writable = 1'b1;
    end else if (a < IOUT_B) begin
      region = REG_ROUT;
      offset = ADDR_W'(a - ROUT_B);
    end else if (a < TOTAL) begin
      region = REG_IOUT;
      offset = ADDR_W'(a - IOUT_B);
    end
  end

endmodule

// File: rtl/fft_reg_bank.sv
// fft_reg_bank
//   Host-visible register bank between the host bus and the FIR/FFT datapath.
//   Holds CTRL/STATUS, GPR, coefficient and FFT in/out regions, a registered
//   read port with valid/error pulses, and the start/busy/done handshake.
//   Ports:
//     clk, arst                 clock, asynchronous active-high reset
//     bus_req/we/addr/wdata     host request, accepted in its cycle
//     bus_rdata/rvalid/err      read data (held), read pulse, reject pulse
//     gpr, coeffs               packed GPR / coefficient storage
//     fft_real_in/imag_in       packed FFT input frame
//     fft_real_out/imag_out     FFT result frame, captured on fft_done
//     fft_start, fft_done       one-cycle handshake with the FFT core
//     irq                       DONE & IRQ_EN
module fft_reg_bank
  import fft_reg_bank_pkg::*;
#(
  parameter  int DATA_WIDTH      = 16,
  parameter  int NUM_GPR_REGS    = 2,
  parameter  int NUM_COEFFS_REGS = 30,
  parameter  int FFT_POINTS      = 8,
  localparam int TOTAL_REGS      = total_regs(NUM_GPR_REGS, NUM_COEFFS_REGS, FFT_POINTS),
  localparam int ADDR_W          = $clog2(TOTAL_REGS)
) (
  input  logic                                  clk,
  input  logic                                  arst,
  input  logic                                  bus_req,
  input  logic                                  bus_we,
  input  logic [ADDR_W-1:0]                     bus_addr,
  input  logic [DATA_WIDTH-1:0]                 bus_wdata,
  output logic [DATA_WIDTH-1:0]                 bus_rdata,
  output logic                                  bus_rvalid,
  output logic                                  bus_err,
  output logic [NUM_GPR_REGS*DATA_WIDTH-1:0]    gpr,
  output logic [NUM_COEFFS_REGS*DATA_WIDTH-1:0] coeffs,
  output logic [FFT_POINTS*DATA_WIDTH-1:0]      fft_real_in,
  output logic [FFT_POINTS*DATA_WIDTH-1:0]      fft_imag_in,
  input  logic [FFT_POINTS*DATA_WIDTH-1:0]      fft_real_out,
  input  logic [FFT_POINTS*DATA_WIDTH-1:0]      fft_imag_out,
  output logic                                  fft_start,
  input  logic                                  fft_done,
  output logic                                  irq
);

  region_e           region;
  logic [ADDR_W-1:0] offset;
  logic              writable;

  fft_reg_decode #(
    .NUM_GPR_REGS   (NUM_GPR_REGS),
    .NUM_COEFFS_REGS(NUM_COEFFS_REGS),
    .FFT_POINTS     (FFT_POINTS),
    .ADDR_W         (ADDR_W)
  ) u_decode (
    .addr    (bus_addr),
    .region  (region),
    .offset  (offset),
    .writable(writable)
  );

  logic [DATA_WIDTH-1:0] ctrl_q, ctrl_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  fft_start_q, fft_start_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;
  logic                  err_q, err_d;

  logic [DATA_WIDTH-1:0] gpr_q  [NUM_GPR_REGS],    gpr_d  [NUM_GPR_REGS];
  logic [DATA_WIDTH-1:0] coef_q [NUM_COEFFS_REGS], coef_d [NUM_COEFFS_REGS];
  logic [DATA_WIDTH-1:0] rin_q  [FFT_POINTS],      rin_d  [FFT_POINTS];
  logic [DATA_WIDTH-1:0] iin_q  [FFT_POINTS],      iin_d  [FFT_POINTS];
  logic [DATA_WIDTH-1:0] rout_q [FFT_POINTS],      rout_d [FFT_POINTS];
  logic [DATA_WIDTH-1:0] iout_q [FFT_POINTS],      iout_d [FFT_POINTS];

  logic                  wr_req, rd_req, wr_ok, done_evt;
  logic [DATA_WIDTH-1:0] rd_val;

  // Read mux works on pre-edge storage, so a read racing fft_done returns
  // the value from before the capture.
  always_comb begin
    rd_val = '0;
    case (region)
      REG_CTRL:   rd_val = ctrl_q;
      REG_STATUS: begin
        rd_val[STATUS_BUSY_BIT] = busy_q;
        rd_val[STATUS_DONE_BIT] = done_q;
      end
      REG_GPR:   for (int i = 0; i < NUM_GPR_REGS; i++)    if (offset == ADDR_W'(i)) rd_val = gpr_q[i];
      REG_COEFF: for (int i = 0; i < NUM_COEFFS_REGS; i++) if (offset == ADDR_W'(i)) rd_val = coef_q[i];
      REG_RIN:   for (int i = 0; i < FFT_POINTS; i++)      if (offset == ADDR_W'(i)) rd_val = rin_q[i];
      REG_IIN:   for (int i = 0; i < FFT_POINTS; i++)      if (offset == ADDR_W'(i)) rd_val = iin_q[i];
      REG_ROUT:  for (int i = 0; i < FFT_POINTS; i++)      if (offset == ADDR_W'(i)) rd_val = rout_q[i];
      REG_IOUT:  for (int i = 0; i < FFT_POINTS; i++)      if (offset == ADDR_W'(i)) rd_val = iout_q[i];
      default:   rd_val = '0;
    endcase
  end

  always_comb begin
    wr_req   = bus_req & bus_we;
    rd_req   = bus_req & ~bus_we;
    done_evt = fft_done & busy_q;
    // While busy the frame inputs are frozen and a restart is refused; a
    // refused CTRL write drops all of its bits, including DONE_CLR.
    wr_ok = writable
          & ~(busy_q & ((region == REG_COEFF) | (region == REG_RIN) | (region == REG_IIN)))
          & ~(busy_q & (region == REG_CTRL) & bus_wdata[CTRL_START_BIT]);

    ctrl_d      = ctrl_q;
    busy_d      = busy_q;
    done_d      = done_q;
    fft_start_d = 1'b0;
    rdata_d     = rdata_q;
    rvalid_d    = 1'b0;
    err_d       = 1'b0;
    gpr_d       = gpr_q;
    coef_d      = coef_q;
    rin_d       = rin_q;
    iin_d       = iin_q;
    rout_d      = rout_q;
    iout_d      = iout_q;

    if (wr_req) begin
      if (!wr_ok) begin
        err_d = 1'b1;
      end else begin
        case (region)
          REG_CTRL: begin
            ctrl_d                    = bus_wdata;
            ctrl_d[CTRL_START_BIT]    = 1'b0;
            ctrl_d[CTRL_DONE_CLR_BIT] = 1'b0;
            if (bus_wdata[CTRL_START_BIT]) begin
              busy_d      = 1'b1;
              fft_start_d = 1'b1;
            end
            if (bus_wdata[CTRL_DONE_CLR_BIT]) done_d = 1'b0;
          end
          REG_GPR:   for (int i = 0; i < NUM_GPR_REGS; i++)    if (offset == ADDR_W'(i)) gpr_d[i]  = bus_wdata;
          REG_COEFF: for (int i = 0; i < NUM_COEFFS_REGS; i++) if (offset == ADDR_W'(i)) coef_d[i] = bus_wdata;
          REG_RIN:   for (int i = 0; i < FFT_POINTS; i++)      if (offset == ADDR_W'(i)) rin_d[i]  = bus_wdata;
          REG_IIN:   for (int i = 0; i < FFT_POINTS; i++)      if (offset == ADDR_W'(i)) iin_d[i]  = bus_wdata;
          default: ;
        endcase
      end
    end

    if (rd_req) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_val;
      if (region == REG_NONE) err_d = 1'b1;
    end

    // Evaluated after the CTRL write so that DONE set wins over DONE_CLR.
    if (done_evt) begin
      busy_d = 1'b0;
      done_d = 1'b1;
      for (int i = 0; i < FFT_POINTS; i++) begin
        rout_d[i] = fft_real_out[i*DATA_WIDTH +: DATA_WIDTH];
        iout_d[i] = fft_imag_out[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      ctrl_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fft_start_q <= 1'b0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      err_q       <= 1'b0;
      gpr_q       <= '{default: '0};
      coef_q      <= '{default: '0};
      rin_q       <= '{default: '0};
      iin_q       <= '{default: '0};
      rout_q      <= '{default: '0};
      iout_q      <= '{default: '0};
    end else begin
      ctrl_q      <= ctrl_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fft_start_q <= fft_start_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      err_q       <= err_d;
      gpr_q       <= gpr_d;
      coef_q      <= coef_d;
      rin_q       <= rin_d;
      iin_q       <= iin_d;
      rout_q      <= rout_d;
      iout_q      <= iout_d;
    end
  end

  assign bus_rdata  = rdata_q;
  assign bus_rvalid = rvalid_q;
  assign bus_err    = err_q;
  assign fft_start  = fft_start_q;
  assign irq        = done_q & ctrl_q[CTRL_IRQ_EN_BIT];

  for (genvar i = 0; i < NUM_GPR_REGS; i++) begin : g_gpr
    assign gpr[i*DATA_WIDTH +: DATA_WIDTH] = gpr_q[i];
  end

  for (genvar i = 0; i < NUM_COEFFS_REGS; i++) begin : g_coef
    assign coeffs[i*DATA_WIDTH +: DATA_WIDTH] = coef_q[i];
  end

  for (genvar i = 0; i < FFT_POINTS; i++) begin : g_fft
    assign fft_real_in[i*DATA_WIDTH +: DATA_WIDTH] = rin_q[i];
    assign fft_imag_in[i*DATA_WIDTH +: DATA_WIDTH] = iin_q[i];
  end

endmodule

// File: tb/tb_fft_reg_bank.sv
// tb_fft_reg_bank
//   Directed bench for fft_reg_bank with default parameters. A flat
//   address-indexed model of the register map is stepped on every clock and
//   compared against all DUT outputs on every falling edge; literal checks
//   pin the key scenarios.
module tb_fft_reg_bank;

  localparam int DW    = 16;
  localparam int NG    = 2;
  localparam int NC    = 30;
  localparam int NP    = 8;
  localparam int TOTAL = 66;
  localparam int AW    = 7;

  logic               clk = 1'b0;
  logic               arst = 1'b1;
  logic               bus_req = 1'b0;
  logic               bus_we = 1'b0;
  logic [AW-1:0]      bus_addr = '0;
  logic [DW-1:0]      bus_wdata = '0;
  logic [DW-1:0]      bus_rdata;
  logic               bus_rvalid;
  logic               bus_err;
  logic [NG*DW-1:0]   gpr;
  logic [NC*DW-1:0]   coeffs;
  logic [NP*DW-1:0]   fft_real_in;
  logic [NP*DW-1:0]   fft_imag_in;
  logic [NP*DW-1:0]   fft_real_out = '0;
  logic [NP*DW-1:0]   fft_imag_out = '0;
  logic               fft_start;
  logic               fft_done = 1'b0;
  logic               irq;

  fft_reg_bank #(
    .DATA_WIDTH     (DW),
    .NUM_GPR_REGS   (NG),
    .NUM_COEFFS_REGS(NC),
    .FFT_POINTS     (NP)
  ) dut (
    .clk         (clk),
    .arst        (arst),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_rdata   (bus_rdata),
    .bus_rvalid  (bus_rvalid),
    .bus_err     (bus_err),
    .gpr         (gpr),
    .coeffs      (coeffs),
    .fft_real_in (fft_real_in),
    .fft_imag_in (fft_imag_in),
    .fft_real_out(fft_real_out),
    .fft_imag_out(fft_imag_out),
    .fft_start   (fft_start),
    .fft_done    (fft_done),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: register value per word address (STATUS computed from flags).
  logic [DW-1:0] m_reg [TOTAL];
  logic          m_busy, m_done, m_start, m_rvalid, m_err;
  logic [DW-1:0] m_rdata;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < TOTAL; i++) m_reg[i] = '0;
    m_busy = 0; m_done = 0; m_start = 0; m_rvalid = 0; m_err = 0; m_rdata = '0;
  endtask

  task automatic model_step();
    int   a;
    logic b, ok;
    if (arst) begin
      model_reset();
      return;
    end
    a = int'(bus_addr);
    b = m_busy;
    m_start = 0; m_rvalid = 0; m_err = 0;
    if (bus_req && bus_we) begin
      ok = (a == 0 && !(b && bus_wdata[0])) || (a >= 2 && a < 4) || (a >= 4 && a < 50 && !b);
      if (!ok) m_err = 1;
      else if (a == 0) begin
        m_reg[0] = bus_wdata & 16'hFFFA;
        if (bus_wdata[0]) begin m_busy = 1; m_start = 1; end
        if (bus_wdata[2]) m_done = 0;
      end else m_reg[a] = bus_wdata;
    end else if (bus_req) begin
      m_rvalid = 1;
      if (a >= TOTAL) begin m_rdata = '0; m_err = 1; end
      else if (a == 1) m_rdata = {14'd0, m_done, m_busy};
      else m_rdata = m_reg[a];
    end
    if (fft_done && b) begin
      for (int i = 0; i < NP; i++) begin
        m_reg[50+i] = fft_real_out[i*DW +: DW];
        m_reg[58+i] = fft_imag_out[i*DW +: DW];
      end
      m_busy = 0;
      m_done = 1;
    end
  endtask

  task automatic compare_all();
    logic [NG*DW-1:0] eg;
    logic [NC*DW-1:0] ec;
    logic [NP*DW-1:0] er, ei;
    for (int i = 0; i < NG; i++) eg[i*DW +: DW] = m_reg[2+i];
    for (int i = 0; i < NC; i++) ec[i*DW +: DW] = m_reg[4+i];
    for (int i = 0; i < NP; i++) begin
      er[i*DW +: DW] = m_reg[34+i];
      ei[i*DW +: DW] = m_reg[42+i];
    end
    check("gpr", 512'(gpr), 512'(eg));
    check("coeffs", 512'(coeffs), 512'(ec));
    check("fft_real_in", 512'(fft_real_in), 512'(er));
    check("fft_imag_in", 512'(fft_imag_in), 512'(ei));
    check("irq", 512'(irq), 512'(m_done & m_reg[0][1]));
    check("fft_start", 512'(fft_start), 512'(m_start));
    check("bus_rvalid", 512'(bus_rvalid), 512'(m_rvalid));
    check("bus_err", 512'(bus_err), 512'(m_err));
    check("bus_rdata", 512'(bus_rdata), 512'(m_rdata));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic bus_wr(input int a, input logic [DW-1:0] d);
    bus_req = 1; bus_we = 1; bus_addr = AW'(a); bus_wdata = d;
    tick();
    bus_req = 0; bus_we = 0;
  endtask

  task automatic bus_rd(input int a);
    bus_req = 1; bus_we = 0; bus_addr = AW'(a);
    tick();
    bus_req = 0;
  endtask

  task automatic set_out(input logic [DW-1:0] base);
    for (int i = 0; i < NP; i++) begin
      fft_real_out[i*DW +: DW] = base + DW'(i);
      fft_imag_out[i*DW +: DW] = base + 16'h0100 + DW'(i);
    end
  endtask

  initial begin
    model_reset();
    repeat (2) tick();
    arst = 0;
    tick();
    check("rst_rdata", 512'(bus_rdata), 512'(0));
    check("rst_irq", 512'(irq), 512'(0));

    // Fill a few storage words across regions.
    bus_wr(2, 16'hA5A5);
    bus_wr(3, 16'h5A5A);
    bus_wr(33, 16'hC0DE);
    bus_wr(42, 16'h0042);
    bus_wr(49, 16'h0049);

    bus_wr(4, 16'h1234);
    check("coeff0_after_wr", 512'(coeffs[15:0]), 512'(16'h1234));
    bus_rd(4);
    check("rd4_rvalid", 512'(bus_rvalid), 512'(1));
    check("rd4_rdata", 512'(bus_rdata), 512'(16'h1234));
    tick();
    check("rvalid_pulse_end", 512'(bus_rvalid), 512'(0));
    check("rdata_held", 512'(bus_rdata), 512'(16'h1234));

    // Frame 1: start, rejected writes while busy, then done.
    bus_wr(0, 16'h0003);
    check("start_pulse", 512'(fft_start), 512'(1));
    tick();
    check("start_one_cycle", 512'(fft_start), 512'(0));
    bus_rd(1);
    check("status_busy", 512'(bus_rdata), 512'(16'h0001));
    bus_wr(34, 16'h7FFF);
    check("rin_busy_err", 512'(bus_err), 512'(1));
    check("rin_unchanged", 512'(fft_real_in[15:0]), 512'(0));
    bus_wr(0, 16'h0001);
    check("restart_busy_err", 512'(bus_err), 512'(1));
    set_out(16'h00AA);
    fft_done = 1;
    tick();
    fft_done = 0;
    check("irq_after_done", 512'(irq), 512'(1));
    bus_rd(50);
    check("rout0", 512'(bus_rdata), 512'(16'h00AA));
    bus_rd(65);
    check("iout7", 512'(bus_rdata), 512'(16'h01B1));
    bus_rd(1);
    check("status_done", 512'(bus_rdata), 512'(16'h0002));
    bus_wr(0, 16'h0004);
    check("irq_cleared", 512'(irq), 512'(0));

    // Read-only and out-of-range accesses.
    bus_wr(1, 16'hFFFF);
    check("wr_status_err", 512'(bus_err), 512'(1));
    bus_wr(50, 16'h5555);
    check("wr_rout_err", 512'(bus_err), 512'(1));
    bus_wr(70, 16'h1111);
    check("wr_oor_err", 512'(bus_err), 512'(1));
    bus_rd(50);
    check("rout0_kept", 512'(bus_rdata), 512'(16'h00AA));
    bus_rd(70);
    check("rd70_rvalid", 512'(bus_rvalid), 512'(1));
    check("rd70_rdata", 512'(bus_rdata), 512'(0));
    check("rd70_err", 512'(bus_err), 512'(1));

    // Frame 2: read of OUT in the done cycle returns pre-capture data.
    bus_wr(0, 16'h0003);
    set_out(16'h0BB0);
    fft_done = 1;
    bus_rd(50);
    fft_done = 0;
    check("rd_race_old", 512'(bus_rdata), 512'(16'h00AA));
    bus_rd(50);
    check("rd_after_new", 512'(bus_rdata), 512'(16'h0BB0));

    // Frame 3: DONE_CLR in the done cycle loses to the DONE set.
    bus_wr(0, 16'h0007);
    bus_rd(1);
    check("status_busy_clr", 512'(bus_rdata), 512'(16'h0001));
    set_out(16'h0CC0);
    fft_done = 1;
    bus_wr(0, 16'h0006);
    fft_done = 0;
    check("set_wins_irq", 512'(irq), 512'(1));
    bus_rd(1);
    check("set_wins_status", 512'(bus_rdata), 512'(16'h0002));

    // Frame 4: START in the done cycle is rejected.
    bus_wr(0, 16'h0003);
    set_out(16'h0DD0);
    fft_done = 1;
    bus_wr(0, 16'h0003);
    fft_done = 0;
    check("start_race_err", 512'(bus_err), 512'(1));
    check("start_race_nopulse", 512'(fft_start), 512'(0));
    bus_rd(1);
    check("status_after_race", 512'(bus_rdata), 512'(16'h0002));

    // fft_done while idle is ignored.
    set_out(16'h0EE0);
    fft_done = 1;
    tick();
    fft_done = 0;
    bus_rd(50);
    check("idle_done_rout", 512'(bus_rdata), 512'(16'h0DD0));
    bus_rd(58);
    check("idle_done_iout", 512'(bus_rdata), 512'(16'h0ED0));

    // Reset asserted mid-frame.
    bus_wr(0, 16'h0001);
    arst = 1;
    #1;
    model_reset();
    check("arst_gpr", 512'(gpr), 512'(0));
    check("arst_coeffs", 512'(coeffs), 512'(0));
    check("arst_imag_in", 512'(fft_imag_in), 512'(0));
    check("arst_start", 512'(fft_start), 512'(0));
    tick();
    tick();
    arst = 0;
    tick();
    set_out(16'h0FF0);
    fft_done = 1;
    tick();
    fft_done = 0;
    bus_rd(50);
    check("post_rst_rout", 512'(bus_rdata), 512'(0));
    bus_rd(1);
    check("post_rst_status", 512'(bus_rdata), 512'(0));
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
